alu_decode_stage: RTL and testbench

Registered, flow-controlled ALU decode stage for the RV32I/RV32M datapath. It sits between fetch and execute. Each cycle it accepts one 32-bit instruction under a valid/ready handshake and decodes the ALU operand-select and a widened ALU control code. The control code adds the M-extension operations and an illegal-instruction flag, and the decoded result is presented through a one-entry output register backed by a one-entry skid register, so `in_ready` is driven from a flop. A saturating counter tracks illegal instructions delivered downstream.

---
 rtl/alu_pkg.sv | 68 ++++++
 rtl/alu_decode_comb.sv | 76 +++++++
 rtl/alu_decode_stage.sv | 102 ++++++++++
 tb/tb_alu_decode_stage.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, funct7 values, ALU control codes
// and the decoded-control bundle passed between decode and execute.
package alu_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_XOR    = 4'd3;
  localparam logic [3:0] ALU_SRL    = 4'd4;
  localparam logic [3:0] ALU_SRA    = 4'd5;
  localparam logic [3:0] ALU_OR     = 4'd6;
  localparam logic [3:0] ALU_AND    = 4'd7;
  localparam logic [3:0] ALU_MUL    = 4'd8;
  localparam logic [3:0] ALU_MULH   = 4'd9;
  localparam logic [3:0] ALU_MULHSU = 4'd10;
  localparam logic [3:0] ALU_MULHU  = 4'd11;
  localparam logic [3:0] ALU_DIV    = 4'd12;
  localparam logic [3:0] ALU_DIVU   = 4'd13;
  localparam logic [3:0] ALU_REM    = 4'd14;
  localparam logic [3:0] ALU_REMU   = 4'd15;

  typedef struct packed {
    logic       alusrc;
    logic [3:0] ctrl;
    logic       cmp;
    logic       uns;
    logic       illegal;
  } alu_dec_t;

  // Base-ISA funct3 mapping shared by R-type and OP-IMM
  function automatic alu_dec_t base_f3(input logic [2:0] f3);
    alu_dec_t d;
    d = '0;
    unique case (f3)
      3'b000: d.ctrl = ALU_ADD;
      3'b001: d.ctrl = ALU_SLL;
      3'b010: begin
        d.ctrl = ALU_SUB;
        d.cmp  = 1'b1;
      end
      3'b011: begin
        d.ctrl = ALU_SUB;
        d.cmp  = 1'b1;
        d.uns  = 1'b1;
      end
      3'b100: d.ctrl = ALU_XOR;
      3'b101: d.ctrl = ALU_SRL;
      3'b110: d.ctrl = ALU_OR;
      3'b111: d.ctrl = ALU_AND;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_decode_comb.sv
// Combinational instruction -> ALU control decode.
// Undecodable encodings come out as illegal with all other fields ADD/0.
module alu_decode_comb
  import alu_pkg::*;
#(
  parameter bit EN_M = 1'b1
) (
  input  logic [31:0] inst_i,
  output alu_dec_t    dec_o
);

  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       is_r, is_i, is_br, is_jal, is_addr;
  alu_dec_t   base;
  logic       unused_ok;

  assign op = inst_i[6:0];
  assign f3 = inst_i[14:12];
  assign f7 = inst_i[31:25];
  assign unused_ok = ^{inst_i[24:15], inst_i[11:7]};

  assign is_r    = (op == OP_R);
  assign is_i    = (op == OP_I);
  assign is_br   = (op == OP_BRANCH);
  assign is_jal  = (op == OP_JAL);
  assign is_addr = (op == OP_LOAD) || (op == OP_STORE) ||
                   (op == OP_JALR) || (op == OP_LUI) ||
                   (op == OP_AUIPC);

  assign base = base_f3(f3);

  always_comb begin
    dec_o         = '0;
    dec_o.illegal = 1'b1;
    unique case (1'b1)
      is_r: begin
        if (f7 == F7_BASE) begin
          dec_o = base;
        end else if (f7 == F7_ALT &&
                     (f3 == 3'b000 || f3 == 3'b101)) begin
          dec_o.illegal = 1'b0;
          dec_o.ctrl    = f3[2] ? ALU_SRA : ALU_SUB;
        end else if (f7 == F7_MULDIV && EN_M) begin
          dec_o.illegal = 1'b0;
          dec_o.ctrl    = {1'b1, f3};
          dec_o.uns     = f3[0] & (f3[1] | f3[2]);
        end
      end
      is_i: begin
        if ((f3 != 3'b001 && f3 != 3'b101) ||
            f7 == F7_BASE) begin
          dec_o        = base;
          dec_o.alusrc = 1'b1;
        end else if (f3 == 3'b101 && f7 == F7_ALT) begin
          dec_o.illegal = 1'b0;
          dec_o.alusrc  = 1'b1;
          dec_o.ctrl    = ALU_SRA;
        end
      end
      is_br: begin
        dec_o.illegal = 1'b0;
        dec_o.ctrl    = ALU_SUB;
        dec_o.uns     = f3[2] & f3[1];
      end
      is_addr: begin
        dec_o.illegal = 1'b0;
        dec_o.alusrc  = 1'b1;
      end
      is_jal: dec_o.illegal = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_decode_stage.sv
// Registered ALU decode stage: output register plus one skid entry,
// registered in_ready, and a saturating illegal-instruction counter.
module alu_decode_stage
  import alu_pkg::*;
#(
  parameter int CTRL_W    = 4,
  parameter bit EN_M      = 1'b1,
  parameter int ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_inst,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_alusrc,
  output logic [CTRL_W-1:0]    out_aluctrl,
  output logic                 out_cmp,
  output logic                 out_unsigned,
  output logic                 out_illegal,
  output logic [ILL_CNT_W-1:0] ill_cnt,
  input  logic                 ill_cnt_clr
);

  alu_dec_t dec;
  alu_dec_t out_q, out_d;
  alu_dec_t skid_q, skid_d;
  logic     out_v_q, out_v_d;
  logic     skid_v_q, skid_v_d;
  logic     rdy_q;
  logic     acc, drain;
  logic [ILL_CNT_W-1:0] cnt_q, cnt_d;

  alu_decode_comb #(.EN_M(EN_M)) u_dec (
    .inst_i (in_inst),
    .dec_o  (dec)
  );

  assign acc   = in_valid & rdy_q;
  assign drain = out_v_q & out_ready;

  always_comb begin
    out_d    = out_q;
    out_v_d  = out_v_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    if (flush) begin
      out_v_d  = 1'b0;
      skid_v_d = 1'b0;
    end else if (!out_v_q || drain) begin
      if (skid_v_q) begin
        out_d    = skid_q;
        out_v_d  = 1'b1;
        skid_v_d = 1'b0;
      end else begin
        out_v_d = acc;
        if (acc) out_d = dec;
      end
    end else if (acc) begin
      skid_d   = dec;
      skid_v_d = 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (ill_cnt_clr)
      cnt_d = '0;
    else if (drain && out_q.illegal && !flush && cnt_q != '1)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q    <= '0;
      out_v_q  <= 1'b0;
      skid_q   <= '0;
      skid_v_q <= 1'b0;
      rdy_q    <= 1'b1;
      cnt_q    <= '0;
    end else begin
      out_q    <= out_d;
      out_v_q  <= out_v_d;
      skid_q   <= skid_d;
      skid_v_q <= skid_v_d;
      rdy_q    <= !skid_v_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready     = rdy_q;
  assign out_valid    = out_v_q;
  assign out_alusrc   = out_q.alusrc;
  assign out_aluctrl  = CTRL_W'(out_q.ctrl);
  assign out_cmp      = out_q.cmp;
  assign out_unsigned = out_q.uns;
  assign out_illegal  = out_q.illegal;
  assign ill_cnt      = cnt_q;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Bench for alu_decode_stage: EN_M=1 and EN_M=0 instances on shared
// inputs, directed table, handshake sequences and random traffic.
module tb_alu_decode_stage;

  typedef struct packed {
    logic       src;
    logic [3:0] ctl;
    logic       cmp;
    logic       uns;
    logic       ill;
  } exp_t;

  typedef struct packed {
    exp_t e1;
    exp_t e0;
  } pair_t;

  typedef struct {
    logic [31:0] inst;
    exp_t        e1;
    logic        ill0;
    logic [3:0]  ctl0;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_inst = '0;
  logic        out_ready = 1'b0;
  logic        ill_cnt_clr = 1'b0;

  logic       ov1, ir1, src1, cmp1, uns1, ill1;
  logic [3:0] ctl1;
  logic [7:0] cnt1;
  logic       ov0, ir0, src0, cmp0, uns0, ill0;
  logic [3:0] ctl0;
  logic [7:0] cnt0;

  int    n_cmp = 0;
  int    n_fail = 0;
  pair_t q[$];
  int    mc1 = 0;
  int    mc0 = 0;
  vec_t  tv[$];

  always #5 clk = ~clk;

  alu_decode_stage #(.CTRL_W(4), .EN_M(1'b1), .ILL_CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(ir1), .in_inst(in_inst),
    .out_valid(ov1), .out_ready(out_ready),
    .out_alusrc(src1), .out_aluctrl(ctl1), .out_cmp(cmp1),
    .out_unsigned(uns1), .out_illegal(ill1),
    .ill_cnt(cnt1), .ill_cnt_clr(ill_cnt_clr)
  );

  alu_decode_stage #(.CTRL_W(4), .EN_M(1'b0), .ILL_CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(ir0), .in_inst(in_inst),
    .out_valid(ov0), .out_ready(out_ready),
    .out_alusrc(src0), .out_aluctrl(ctl0), .out_cmp(cmp0),
    .out_unsigned(uns0), .out_illegal(ill0),
    .ill_cnt(cnt0), .ill_cnt_clr(ill_cnt_clr)
  );

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input bit s, input int c,
                              input bit cm, input bit u);
    exp_t e;
    e.src = s;
    e.ctl = 4'(c);
    e.cmp = cm;
    e.uns = u;
    e.ill = 1'b0;
    return e;
  endfunction

  // Reference decode, written instruction by instruction
  function automatic exp_t model(input logic [31:0] in, input bit en);
    exp_t       e;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op = in[6:0];
    f3 = in[14:12];
    f7 = in[31:25];
    e = '0;
    e.ill = 1'b1;
    case (op)
      7'h33: begin
        if (f7 == 7'h01) begin
          if (en) e = mk(0, 8 + int'(f3), 0, f3 == 3 || f3 == 5 || f3 == 7);
        end else begin
          case ({f7, f3})
            10'b0000000_000: e = mk(0, 0, 0, 0);
            10'b0000000_001: e = mk(0, 2, 0, 0);
            10'b0000000_010: e = mk(0, 1, 1, 0);
            10'b0000000_011: e = mk(0, 1, 1, 1);
            10'b0000000_100: e = mk(0, 3, 0, 0);
            10'b0000000_101: e = mk(0, 4, 0, 0);
            10'b0000000_110: e = mk(0, 6, 0, 0);
            10'b0000000_111: e = mk(0, 7, 0, 0);
            10'b0100000_000: e = mk(0, 1, 0, 0);
            10'b0100000_101: e = mk(0, 5, 0, 0);
            default: ;
          endcase
        end
      end
      7'h13: begin
        case (f3)
          3'd0: e = mk(1, 0, 0, 0);
          3'd1: if (f7 == 0) e = mk(1, 2, 0, 0);
          3'd2: e = mk(1, 1, 1, 0);
          3'd3: e = mk(1, 1, 1, 1);
          3'd4: e = mk(1, 3, 0, 0);
          3'd5: begin
            if (f7 == 0) e = mk(1, 4, 0, 0);
            else if (f7 == 7'h20) e = mk(1, 5, 0, 0);
          end
          3'd6: e = mk(1, 6, 0, 0);
          default: e = mk(1, 7, 0, 0);
        endcase
      end
      7'h03, 7'h23, 7'h67, 7'h37, 7'h17: e = mk(1, 0, 0, 0);
      7'h6F: e = mk(0, 0, 0, 0);
      7'h63: e = mk(0, 1, 0, f3 >= 6);
      default: ;
    endcase
    return e;
  endfunction

  task automatic check_state();
    chk("out_valid1", int'(ov1), int'(q.size() > 0));
    chk("in_ready1", int'(ir1), int'(q.size() < 2));
    chk("ill_cnt1", int'(cnt1), mc1);
    chk("out_valid0", int'(ov0), int'(q.size() > 0));
    chk("in_ready0", int'(ir0), int'(q.size() < 2));
    chk("ill_cnt0", int'(cnt0), mc0);
    if (q.size() > 0) begin
      chk("alusrc1", int'(src1), int'(q[0].e1.src));
      chk("aluctrl1", int'(ctl1), int'(q[0].e1.ctl));
      chk("cmp1", int'(cmp1), int'(q[0].e1.cmp));
      chk("unsigned1", int'(uns1), int'(q[0].e1.uns));
      chk("illegal1", int'(ill1), int'(q[0].e1.ill));
      chk("alusrc0", int'(src0), int'(q[0].e0.src));
      chk("aluctrl0", int'(ctl0), int'(q[0].e0.ctl));
      chk("cmp0", int'(cmp0), int'(q[0].e0.cmp));
      chk("unsigned0", int'(uns0), int'(q[0].e0.uns));
      chk("illegal0", int'(ill0), int'(q[0].e0.ill));
    end
  endtask

  // Called at a falling edge: check, drive, advance model, wait one cycle
  task automatic step(input bit iv, input logic [31:0] inst,
                      input bit ordy, input bit fl, input bit clr);
    bit ixf, oxf;
    pair_t p;
    check_state();
    in_valid    = iv;
    in_inst     = inst;
    out_ready   = ordy;
    flush       = fl;
    ill_cnt_clr = clr;
    ixf = iv && (q.size() < 2);
    oxf = ordy && (q.size() > 0);
    if (clr) begin
      mc1 = 0;
      mc0 = 0;
    end else if (oxf && !fl) begin
      if (q[0].e1.ill && mc1 < 255) mc1++;
      if (q[0].e0.ill && mc0 < 255) mc0++;
    end
    if (fl) begin
      q.delete();
    end else begin
      if (oxf) void'(q.pop_front());
      if (ixf) begin
        p.e1 = model(inst, 1'b1);
        p.e0 = model(inst, 1'b0);
        q.push_back(p);
      end
    end
    @(negedge clk);
  endtask

  task automatic addv(input logic [31:0] inst, input bit s, input int c,
                      input bit cm, input bit u, input bit il,
                      input bit il0, input int c0);
    vec_t v;
    v.inst = inst;
    v.e1 = mk(s, c, cm, u);
    v.e1.ill = il;
    v.ill0 = il0;
    v.ctl0 = 4'(c0);
    tv.push_back(v);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    logic [6:0]  ops [12];
    logic [6:0]  f7s [4];
    ops = '{7'h33, 7'h33, 7'h13, 7'h13, 7'h03, 7'h23, 7'h63,
            7'h67, 7'h6F, 7'h37, 7'h17, 7'h7F};
    f7s = '{7'h00, 7'h20, 7'h01, 7'h00};
    w = $urandom;
    w[6:0] = ops[$urandom_range(0, 11)];
    if ($urandom_range(0, 7) != 0) w[31:25] = f7s[$urandom_range(0, 3)];
    if ($urandom_range(0, 15) == 0) w[6:0] = 7'($urandom);
    return w;
  endfunction

  initial begin
    int    idx, lowcnt, deliv, c1, c0;
    logic [31:0] bp [4];

    repeat (2) @(negedge clk);
    chk("rst out_valid", int'(ov1), 0);
    chk("rst in_ready", int'(ir1), 1);
    chk("rst aluctrl", int'(ctl1), 0);
    chk("rst alusrc", int'(src1), 0);
    chk("rst illegal", int'(ill1), 0);
    chk("rst ill_cnt", int'(cnt1), 0);
    check_state();
    rst_n = 1'b1;

    addv(32'h00B50533, 0, 0, 0, 0, 0, 0, 0);
    addv(32'h4030D093, 1, 5, 0, 0, 0, 0, 5);
    addv(32'h00B53533, 0, 1, 1, 1, 0, 0, 1);
    addv(32'h02B55533, 0, 13, 0, 1, 0, 1, 0);
    addv(32'h02B53533, 0, 11, 0, 1, 0, 1, 0);
    addv(32'h02B50533, 0, 8, 0, 0, 0, 1, 0);
    addv(32'h02B56533, 0, 14, 0, 0, 0, 1, 0);
    addv(32'h40B50533, 0, 1, 0, 0, 0, 0, 1);
    addv(32'h0000007F, 0, 0, 0, 0, 1, 1, 0);
    addv(32'h00B56463, 0, 1, 0, 1, 0, 0, 1);
    addv(32'h123452B7, 1, 0, 0, 0, 0, 0, 0);
    addv(32'h0000006F, 0, 0, 0, 0, 0, 0, 0);
    addv(32'h40109093, 0, 0, 0, 0, 1, 1, 0);
    addv(32'h40B51533, 0, 0, 0, 0, 1, 1, 0);
    addv(32'h00A52513, 1, 1, 1, 0, 0, 0, 1);
    addv(32'h20B50533, 0, 0, 0, 0, 1, 1, 0);
    addv(32'h00052503, 1, 0, 0, 0, 0, 0, 0);
    addv(32'h00A56513, 1, 6, 0, 0, 0, 0, 6);

    foreach (tv[i]) begin
      step(1'b1, tv[i].inst, 1'b1, 1'b0, 1'b0);
      chk($sformatf("tv%0d valid", i), int'(ov1), 1);
      chk($sformatf("tv%0d alusrc", i), int'(src1), int'(tv[i].e1.src));
      chk($sformatf("tv%0d aluctrl", i), int'(ctl1), int'(tv[i].e1.ctl));
      chk($sformatf("tv%0d cmp", i), int'(cmp1), int'(tv[i].e1.cmp));
      chk($sformatf("tv%0d unsigned", i), int'(uns1), int'(tv[i].e1.uns));
      chk($sformatf("tv%0d illegal", i), int'(ill1), int'(tv[i].e1.ill));
      chk($sformatf("tv%0d illegal noM", i), int'(ill0), int'(tv[i].ill0));
      chk($sformatf("tv%0d aluctrl noM", i), int'(ctl0), int'(tv[i].ctl0));
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    end

    bp = '{32'h00B50533, 32'h02B55533, 32'h4030D093, 32'h0000007F};
    idx = 0;
    lowcnt = 0;
    deliv = 0;
    for (int cyc = 0; cyc < 20 && (idx < 4 || q.size() > 0); cyc++) begin
      bit iv, ordy, acc;
      iv = idx < 4;
      ordy = !(cyc >= 1 && cyc <= 3);
      if (!ir1) lowcnt++;
      if (ov1 && ordy) deliv++;
      acc = iv && ir1;
      step(iv, iv ? bp[idx] : 32'h0, ordy, 1'b0, 1'b0);
      if (acc) idx++;
    end
    chk("bp accepted", idx, 4);
    chk("bp delivered", deliv, 4);
    chk("bp ready-low cycles", lowcnt, 3);

    step(1'b1, 32'h0000007F, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0000007F, 1'b0, 1'b0, 1'b0);
    chk("full in_ready", int'(ir1), 0);
    chk("full out_valid", int'(ov1), 1);
    c1 = int'(cnt1);
    c0 = int'(cnt0);
    step(1'b1, 32'h00B50533, 1'b1, 1'b1, 1'b0);
    chk("flush out_valid", int'(ov1), 0);
    chk("flush in_ready", int'(ir1), 1);
    chk("flush ill_cnt1", int'(cnt1), c1);
    chk("flush ill_cnt0", int'(cnt0), c0);

    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 260; i++)
      step(1'b1, 32'h0000007F, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("sat ill_cnt1", int'(cnt1), 255);
    chk("sat ill_cnt0", int'(cnt0), 255);
    step(1'b1, 32'h0000007F, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    chk("clr wins ill_cnt1", int'(cnt1), 0);
    chk("clr wins ill_cnt0", int'(cnt0), 0);
    chk("clr delivered", int'(ov1), 0);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, rand_inst(),
           $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0,
           $urandom_range(0, 59) == 0);
    end

    for (int i = 0; i < 6; i++)
      step(1'b1, rand_inst(), 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst out_valid", int'(ov1), 0);
    chk("async rst in_ready", int'(ir1), 1);
    chk("async rst ill_cnt", int'(cnt1), 0);
    q.delete();
    mc1 = 0;
    mc0 = 0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 32'h02B55533, 1'b1, 1'b0, 1'b0);
    chk("post-rst aluctrl", int'(ctl1), 13);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check_state();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
